// File: rtl/and_unit_arbiter.sv
// and_unit_arbiter
// Shares one registered bitwise AND unit among four requesters. A requester
// is granted in IDLE and its operands are latched. The AND is computed in EXEC,
// and the result is presented with a one-cycle done pulse. The grant is
// released in RESP.
//
// Build option: define AND_ARB_FIXED_PRIO_EN for fixed priority (requester 0
// highest). Leave it undefined for round-robin arbitration, which starts the
// search one past the last winner.
module and_unit_arbiter #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [3:0]         req,
    input  logic [4*WIDTH-1:0] a_bus,
    input  logic [4*WIDTH-1:0] b_bus,
    output logic [3:0]         gnt,
    output logic               busy,
    output logic               done,
    output logic [WIDTH-1:0]   z
);

    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_EXEC = 2'b01;
    localparam logic [1:0] ST_RESP = 2'b10;

    logic [1:0]       state_reg;
    logic [3:0]       gnt_reg;
    logic             done_reg;
    logic [WIDTH-1:0] z_reg;
    logic [WIDTH-1:0] a_q_reg;
    logic [WIDTH-1:0] b_q_reg;
`ifndef AND_ARB_FIXED_PRIO_EN
    logic [1:0]       win_reg;
    logic [1:0]       last_reg;
    logic [1:0]       cand;
`endif

    logic             sel_valid;
    logic [1:0]       sel_idx;
    logic [WIDTH-1:0] a_arr [4];
    logic [WIDTH-1:0] b_arr [4];

    // Unpack the per-requester operand slices.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_unpack
            assign a_arr[gi] = a_bus[gi*WIDTH +: WIDTH];
            assign b_arr[gi] = b_bus[gi*WIDTH +: WIDTH];
        end
    endgenerate

    // Winner selection. The loop walks from lowest to highest priority, so the
    // last asserted request that the loop visits is the one that wins.
    always_comb begin
        sel_valid = 1'b0;
        sel_idx   = 2'd0;
`ifdef AND_ARB_FIXED_PRIO_EN
        for (int k = 3; k >= 0; k--) begin
            if (req[k]) begin
                sel_valid = 1'b1;
                sel_idx   = 2'(k);
            end
        end
`else
        cand = 2'd0;
        // The candidate at offset 4 wraps back to last_reg. That is the lowest
        // priority, so the previous winner goes behind everyone else.
        for (int k = 4; k >= 1; k--) begin
            cand = last_reg + 2'(k);
            if (req[cand]) begin
                sel_valid = 1'b1;
                sel_idx   = cand;
            end
        end
`endif
    end

    // Transaction sequencer: grant and latch, then compute, then release.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= ST_IDLE;
            gnt_reg   <= 4'b0000;
            done_reg  <= 1'b0;
            z_reg     <= '0;
            a_q_reg   <= '0;
            b_q_reg   <= '0;
`ifndef AND_ARB_FIXED_PRIO_EN
            win_reg   <= 2'd0;
            last_reg  <= 2'd3;
`endif
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (sel_valid) begin
                        gnt_reg   <= 4'b0001 << sel_idx;
                        a_q_reg   <= a_arr[sel_idx];
                        b_q_reg   <= b_arr[sel_idx];
`ifndef AND_ARB_FIXED_PRIO_EN
                        win_reg   <= sel_idx;
`endif
                        state_reg <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    z_reg     <= a_q_reg & b_q_reg;
                    done_reg  <= 1'b1;
                    state_reg <= ST_RESP;
                end
                ST_RESP: begin
                    done_reg  <= 1'b0;
                    gnt_reg   <= 4'b0000;
`ifndef AND_ARB_FIXED_PRIO_EN
                    last_reg  <= win_reg;
`endif
                    state_reg <= ST_IDLE;
                end
                default: begin
                    done_reg  <= 1'b0;
                    gnt_reg   <= 4'b0000;
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    assign gnt  = gnt_reg;
    assign done = done_reg;
    assign z    = z_reg;
    assign busy = (state_reg != ST_IDLE);

endmodule

// File: tb/tb_and_unit_arbiter.sv
// Testbench for and_unit_arbiter. A transaction-level reference model is
// compared against the DUT on every falling edge. Directed scenarios pin the
// model with literal expectations, and a randomized phase follows them.
// Honours AND_ARB_FIXED_PRIO_EN in the same way as the design.
module tb_and_unit_arbiter;
    localparam int W = 8;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [3:0]     req = 4'b0000;
    logic [4*W-1:0] a_bus = '0;
    logic [4*W-1:0] b_bus = '0;
    logic [3:0]     gnt;
    logic           busy;
    logic           done;
    logic [W-1:0]   z;

    int n_cmp = 0;
    int n_bad = 0;

    and_unit_arbiter #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .req(req), .a_bus(a_bus), .b_bus(b_bus),
        .gnt(gnt), .busy(busy), .done(done), .z(z)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h required %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // m_owner is the index of the current transaction owner, or -1 when idle.
    // m_age counts the clock edges since the grant edge.
    int           m_owner = -1;
    int           m_age   = 0;
    int           m_last  = 3;
    logic [W-1:0] m_a = '0, m_b = '0, m_z = '0;

    function automatic int pick(input logic [3:0] r, input int last);
`ifdef AND_ARB_FIXED_PRIO_EN
        for (int i = 0; i < 4; i++) if (r[i]) return i;
`else
        for (int k = 1; k <= 4; k++) if (r[(last + k) % 4]) return (last + k) % 4;
`endif
        return -1;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_owner = -1; m_age = 0; m_last = 3;
            m_a = '0; m_b = '0; m_z = '0;
        end else if (m_owner < 0) begin
            int w;
            w = pick(req, m_last);
            if (w >= 0) begin
                m_owner = w;
                m_a     = a_bus[w*W +: W];
                m_b     = b_bus[w*W +: W];
                m_age   = 1;
            end
        end else begin
            m_age++;
            if (m_age == 2) m_z = m_a & m_b;
            else if (m_age == 3) begin
                m_last  = m_owner;
                m_owner = -1;
                m_age   = 0;
            end
        end
    end

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        if (!rst) begin
            check("gnt",  {28'd0, gnt},  (m_owner >= 0) ? (32'd1 << m_owner) : 32'd0);
            check("busy", {31'd0, busy}, {31'd0, (m_owner >= 0)});
            check("done", {31'd0, done}, {31'd0, (m_owner >= 0 && m_age == 2)});
            check("z",    {24'd0, z},    {24'd0, m_z});
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic set_op(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
        a_bus[i*W +: W] = a;
        b_bus[i*W +: W] = b;
    endtask

    function automatic int idx_of(input logic [3:0] g);
        for (int i = 0; i < 4; i++) if (g[i]) return i;
        return -1;
    endfunction

    logic [W-1:0] ra [4];
    logic [W-1:0] rb [4];
    int           order[$];
    int           exp_order [5];
    int           prev_t;

    initial begin
        // Reset state
        rst = 1'b1;
        tick(); tick();
        check("rst_gnt",  {28'd0, gnt},  32'h0);
        check("rst_busy", {31'd0, busy}, 32'h0);
        check("rst_done", {31'd0, done}, 32'h0);
        check("rst_z",    {24'd0, z},    32'h0);
        rst = 1'b0;
        tick();

        // Single requester 2
        set_op(2, 8'hF0, 8'h3C);
        req = 4'b0100;
        tick();
        check("single_gnt",  {28'd0, gnt},  32'h4);
        check("single_busy", {31'd0, busy}, 32'h1);
        tick();
        check("single_done", {31'd0, done}, 32'h1);
        check("single_z",    {24'd0, z},    32'h30);
        req = 4'b0000;
        tick();
        check("single_idle", {31'd0, busy}, 32'h0);
        tick();

        // Operand stability: a later change to b0 must not affect the result
        set_op(0, 8'hFF, 8'hAA);
        req = 4'b0001;
        tick();
        set_op(0, 8'hFF, 8'h00);
        tick();
        check("stable_done", {31'd0, done}, 32'h1);
        check("stable_z",    {24'd0, z},    32'hAA);
        req = 4'b0000;
        tick(); tick();

        // Withdrawn request
        set_op(0, 8'h5A, 8'h0F);
        req = 4'b0001;
        tick();
        check("wd_gnt", {28'd0, gnt}, 32'h1);
        req = 4'b0000;
        tick();
        check("wd_done", {31'd0, done}, 32'h1);
        check("wd_z",    {24'd0, z},    32'h0A);
        tick();
        check("wd_gnt_off", {28'd0, gnt},  32'h0);
        check("wd_busy",    {31'd0, busy}, 32'h0);
        tick();

        // Asynchronous reset in the middle of EXEC
        set_op(0, 8'h33, 8'h77);
        req = 4'b0001;
        tick();
        rst = 1'b1;
        #1;
        check("mid_rst_gnt",  {28'd0, gnt},  32'h0);
        check("mid_rst_busy", {31'd0, busy}, 32'h0);
        check("mid_rst_done", {31'd0, done}, 32'h0);
        check("mid_rst_z",    {24'd0, z},    32'h0);
        tick();
        rst = 1'b0;
        req = 4'b0010;
        tick();
        check("post_rst_gnt", {28'd0, gnt}, 32'h2);
        req = 4'b0000;
        tick(); tick(); tick();

        // All four requesters held; check the grant order and each result
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            ra[i] = 8'(8'h3C + 8'h51 * i);
            rb[i] = 8'(8'hE7 - 8'h22 * i);
            set_op(i, ra[i], rb[i]);
        end
`ifdef AND_ARB_FIXED_PRIO_EN
        exp_order = '{0, 0, 0, 0, 0};
`else
        exp_order = '{0, 1, 2, 3, 0};
`endif
        req = 4'b1111;
        prev_t = -1;
        for (int t = 0; t < 16; t++) begin
            tick();
            if (done) begin
                order.push_back(idx_of(gnt));
                if (idx_of(gnt) >= 0)
                    check("rr_z", {24'd0, z}, {24'd0, ra[idx_of(gnt)] & rb[idx_of(gnt)]});
                if (prev_t >= 0) check("rr_gap", 32'(t - prev_t), 32'd3);
                prev_t = t;
            end
        end
        req = 4'b0000;
        check("rr_count", {31'd0, (order.size() >= 5)}, 32'd1);
        if (order.size() >= 5)
            for (int i = 0; i < 5; i++) check("rr_order", 32'(order[i]), 32'(exp_order[i]));
        tick(); tick(); tick();

`ifdef AND_ARB_FIXED_PRIO_EN
        // Fixed priority: requester 1 always beats requester 3
        req = 4'b1010;
        for (int t = 0; t < 15; t++) begin
            tick();
            check("fp_no_gnt3", {31'd0, gnt[3]}, 32'd0);
            if (done) check("fp_owner", {28'd0, gnt}, 32'h2);
        end
        req = 4'b0000;
        tick(); tick(); tick();
`endif

        // Randomized traffic with occasional resets
        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(0, 79) == 0) begin
                rst = 1'b1;
                tick();
                rst = 1'b0;
            end
            req   = ($urandom_range(0, 3) == 0) ? 4'b0000 : 4'($urandom);
            a_bus = {$urandom, $urandom} [4*W-1:0];
            b_bus = {$urandom, $urandom} [4*W-1:0];
            tick();
        end
        req = 4'b0000;
        tick(); tick(); tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
